// File: rtl/lsu_mem_ctrl_if.sv
// Execute-stage request, data-bus and load-writeback signals of the load/store unit.
interface lsu_mem_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_load_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        misalign_o;
    logic        busy_o;

    modport slave (
        input  req_valid_i, req_load_i, req_size_i, req_unsigned_i, req_addr_i,
               req_wdata_i, req_rd_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
               reg_we_o, reg_waddr_o, reg_wdata_o, misalign_o, busy_o
    );

    modport master (
        output req_valid_i, req_load_i, req_size_i, req_unsigned_i, req_addr_i,
               req_wdata_i, req_rd_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
               reg_we_o, reg_waddr_o, reg_wdata_o, misalign_o, busy_o
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: one outstanding access, load lane extraction, store formatting.
// Optional LSU_BYTE_STROBE_EN: sub-word stores use byte strobes instead of read-modify-write.
module lsu_mem_ctrl (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_ctrl_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned STRBW = XLEN / 8;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, RREQ, RWAIT, WREQ} state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            load_q, load_d, uns_q, uns_d, flushed_q, flushed_d;
    logic [REGW-1:0] rd_q, rd_d;
    logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic            reg_we_q, reg_we_d, misalign_q, misalign_d, busy_q, busy_d;
    logic [REGW-1:0] reg_waddr_q, reg_waddr_d;
    logic [XLEN-1:0] reg_wdata_q, reg_wdata_d;
    logic            accept_c, misaligned_c;
    logic [XLEN-1:0] load_data_c, store_data_c;
    logic [7:0]      lane_b_c;
    logic [15:0]     lane_h_c;
`ifdef LSU_BYTE_STROBE_EN
    logic [STRBW-1:0] wstrb_q, wstrb_d, store_strb_c;
`else
    logic [XLEN-1:0]  merge_q, merge_d, merged_c;
`endif

    // Ready is combinational on flush so a flush cycle never accepts a request.
    assign bus.req_ready_o = rst & ~bus.flush_i & (state == IDLE);
    assign accept_c        = bus.req_valid_i & bus.req_ready_o;

    // Request decode, load lane extraction and sub-word merge.
    always_comb begin
        misaligned_c = (bus.req_size_i == 2'b11)
                     | ((bus.req_size_i == SZ_HALF) & bus.req_addr_i[0])
                     | ((bus.req_size_i == SZ_WORD) & (bus.req_addr_i[1:0] != 2'b00));
        lane_b_c = 8'(bus.mem_rdata_i >> {addr_q[1:0], 3'b000});
        lane_h_c = 16'(bus.mem_rdata_i >> {addr_q[1], 4'b0000});
        unique case (size_q)
            SZ_BYTE: load_data_c = uns_q ? {24'd0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
            SZ_HALF: load_data_c = uns_q ? {16'd0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
            default: load_data_c = bus.mem_rdata_i;
        endcase
`ifndef LSU_BYTE_STROBE_EN
        merged_c = bus.mem_rdata_i;
        if (size_q == SZ_BYTE) merged_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                   merged_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
`endif
    end

    // Next state, capture registers and registered outputs.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        load_d      = load_q;
        uns_d       = uns_q;
        rd_d        = rd_q;
        flushed_d   = flushed_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = '0;
        reg_wdata_d = '0;
        misalign_d  = 1'b0;
`ifndef LSU_BYTE_STROBE_EN
        merge_d     = merge_q;
`endif
        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    addr_d    = bus.req_addr_i;
                    wdata_d   = bus.req_wdata_i;
                    size_d    = bus.req_size_i;
                    load_d    = bus.req_load_i;
                    uns_d     = bus.req_unsigned_i;
                    rd_d      = bus.req_rd_i;
                    flushed_d = 1'b0;
                    if (misaligned_c)        misalign_d = 1'b1;
                    else if (bus.req_load_i) state_d    = RREQ;
`ifdef LSU_BYTE_STROBE_EN
                    else                     state_d    = WREQ;
`else
                    else if (bus.req_size_i == SZ_WORD) state_d = WREQ;
                    else                     state_d    = RREQ;
`endif
                end
            end
            RREQ: begin
                // A flush coinciding with grant must still drain the returning read.
                if (bus.mem_gnt_i) begin
                    state_d   = RWAIT;
                    flushed_d = bus.flush_i;
                end else if (bus.flush_i) begin
                    state_d = IDLE;
                end
            end
            RWAIT: begin
                if (bus.flush_i) flushed_d = 1'b1;
                if (bus.mem_rvalid_i) begin
                    if (flushed_q | bus.flush_i) begin
                        state_d = IDLE;
                    end else if (load_q) begin
                        reg_we_d    = 1'b1;
                        reg_waddr_d = rd_q;
                        reg_wdata_d = load_data_c;
                        state_d     = IDLE;
                    end else begin
`ifndef LSU_BYTE_STROBE_EN
                        merge_d = merged_c;
`endif
                        state_d = WREQ;
                    end
                end
            end
            WREQ: begin
                if (bus.mem_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef LSU_BYTE_STROBE_EN
        unique case (size_d)
            SZ_BYTE: begin
                store_data_c = {4{wdata_d[7:0]}};
                store_strb_c = 4'b0001 << addr_d[1:0];
            end
            SZ_HALF: begin
                store_data_c = {2{wdata_d[15:0]}};
                store_strb_c = addr_d[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data_c = wdata_d;
                store_strb_c = 4'b1111;
            end
        endcase
`else
        store_data_c = (size_d == SZ_WORD) ? wdata_d : merge_d;
`endif
        mem_req_d   = (state_d == RREQ) | (state_d == WREQ);
        mem_we_d    = (state_d == WREQ);
        mem_addr_d  = mem_req_d ? {addr_d[XLEN-1:2], 2'b00} : '0;
        mem_wdata_d = mem_we_d ? store_data_c : '0;
        busy_d      = (state_d != IDLE);
`ifdef LSU_BYTE_STROBE_EN
        wstrb_d     = mem_we_d ? store_strb_c : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            load_q      <= 1'b0;
            uns_q       <= 1'b0;
            rd_q        <= '0;
            flushed_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            misalign_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef LSU_BYTE_STROBE_EN
            wstrb_q     <= '0;
`else
            merge_q     <= '0;
`endif
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            load_q      <= load_d;
            uns_q       <= uns_d;
            rd_q        <= rd_d;
            flushed_q   <= flushed_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            misalign_q  <= misalign_d;
            busy_q      <= busy_d;
`ifdef LSU_BYTE_STROBE_EN
            wstrb_q     <= wstrb_d;
`else
            merge_q     <= merge_d;
`endif
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.reg_we_o    = reg_we_q;
    assign bus.reg_waddr_o = reg_waddr_q;
    assign bus.reg_wdata_o = reg_wdata_q;
    assign bus.misalign_o  = misalign_q;
    assign bus.busy_o      = busy_q;
`ifdef LSU_BYTE_STROBE_EN
    assign bus.mem_wstrb_o = wstrb_q;
`else
    // Full-word strobes outside reset; sub-word stores are merged before writing.
    assign bus.mem_wstrb_o = {STRBW{rst}};
`endif
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a per-cycle timeline model of each access checked every cycle.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        mreq;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        rwe;
        logic [4:0]  waddr;
        logic [31:0] rdat;
        logic        mis;
        logic        busy;
    } out_t;

    out_t exp;
    logic chk_en = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t act=%h req=%h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("req_ready", 32'(bus.req_ready_o), 32'(exp.ready));
            cmp("mem_req",   32'(bus.mem_req_o),   32'(exp.mreq));
            cmp("mem_we",    32'(bus.mem_we_o),    32'(exp.we));
            cmp("mem_addr",  bus.mem_addr_o,       exp.addr);
            cmp("mem_wdata", bus.mem_wdata_o,      exp.wdata);
            cmp("mem_wstrb", 32'(bus.mem_wstrb_o), 32'(exp.strb));
            cmp("reg_we",    32'(bus.reg_we_o),    32'(exp.rwe));
            cmp("reg_waddr", 32'(bus.reg_waddr_o), 32'(exp.waddr));
            cmp("reg_wdata", bus.reg_wdata_o,      exp.rdat);
            cmp("misalign",  32'(bus.misalign_o),  32'(exp.mis));
            cmp("busy",      32'(bus.busy_o),      32'(exp.busy));
        end
    end

    // Spec-level helpers: extension, merge and strobe-mode formatting as plain arithmetic.
    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        v = rd >> (8 * a[1:0]);
        if (sz == 2'b00) begin
            v = v & 32'h0000_00FF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] rmw_merge(input logic [31:0] rd, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] m;
        m = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * a[1:0]);
        return (rd & ~m) | ((wd << (8 * a[1:0])) & m);
    endfunction

    function automatic logic [31:0] rep_data(input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] rep_strb(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b00) return 4'(1 << a[1:0]);
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.req_valid_i    = 1'b0;
        bus.req_load_i     = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'd0;
        bus.req_wdata_i    = 32'd0;
        bus.req_rd_i       = 5'd0;
        bus.flush_i        = 1'b0;
        bus.mem_gnt_i      = 1'b0;
        bus.mem_rvalid_i   = 1'b0;
        bus.mem_rdata_i    = 32'd0;
    endtask

    task automatic set_idle();
        exp       = '0;
        exp.ready = rst & ~bus.flush_i;
`ifdef LSU_BYTE_STROBE_EN
        exp.strb  = 4'h0;
`else
        exp.strb  = {4{rst}};
`endif
    endtask

    task automatic set_busy();
        set_idle();
        exp.ready = 1'b0;
        exp.busy  = 1'b1;
    endtask

    // One access; gw = grant wait cycles, rw = rvalid wait cycles, fl_rreq = RREQ cycle index of flush.
    task automatic access(input logic ld, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int gw, input int rw, input logic [31:0] rdata,
                          input int fl_rreq, input bit fl_rwait, input bit fl_wreq,
                          input bit rv_gnt, input bit has_lit, input logic [31:0] lit);
        logic [31:0] al, sd;
        logic [3:0]  sb;
        bit mis, rmw, sup;
        al  = a & 32'hFFFF_FFFC;
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        rmw = 1'b0;
        sup = fl_rwait || (fl_rreq == gw);
`ifndef LSU_BYTE_STROBE_EN
        rmw = !ld && sz != 2'b10;
`endif
        clr_in();
        bus.req_valid_i = 1'b1; bus.req_load_i = ld; bus.req_size_i = sz;
        bus.req_unsigned_i = uns; bus.req_addr_i = a; bus.req_wdata_i = wd; bus.req_rd_i = rd;
        set_idle();
        step();
        clr_in();
        if (mis) begin
            set_idle(); exp.mis = 1'b1; step();
            set_idle(); step();
            return;
        end
        if (ld || rmw) begin
            for (int i = 0; i <= gw; i++) begin
                clr_in();
                bus.mem_gnt_i = (i == gw);
                bus.flush_i   = (i == fl_rreq);
                if (i == gw && rv_gnt) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = ~rdata;
                end
                set_busy(); exp.mreq = 1'b1; exp.addr = al;
                step();
                if (i == fl_rreq && i != gw) begin
                    clr_in(); set_idle(); step();
                    set_idle(); step();
                    return;
                end
            end
            for (int j = 0; j <= rw; j++) begin
                clr_in();
                bus.mem_rvalid_i = (j == rw);
                bus.mem_rdata_i  = rdata;
                bus.flush_i      = fl_rwait && j == 0;
                set_busy();
                step();
            end
            clr_in();
            if (sup) begin
                set_idle(); step();
                set_idle(); step();
                return;
            end
            if (ld) begin
                set_idle(); exp.rwe = 1'b1; exp.waddr = rd; exp.rdat = load_ext(rdata, a, sz, uns);
                if (has_lit) begin
                    @(negedge clk);
                    cmp("lit_load", bus.reg_wdata_o, lit);
                end
                step();
                set_idle(); step();
                return;
            end
            sd = rmw_merge(rdata, wd, a, sz);
            sb = 4'hF;
        end else begin
`ifdef LSU_BYTE_STROBE_EN
            sd = rep_data(wd, sz);
            sb = rep_strb(a, sz);
`else
            sd = wd;
            sb = 4'hF;
`endif
        end
        for (int i = 0; i <= gw; i++) begin
            clr_in();
            bus.mem_gnt_i = (i == gw);
            bus.flush_i   = fl_wreq && i == 0;
            set_busy(); exp.mreq = 1'b1; exp.we = 1'b1; exp.addr = al; exp.wdata = sd; exp.strb = sb;
            if (has_lit && i == 0) begin
                @(negedge clk);
                cmp("lit_store", bus.mem_wdata_o, lit);
            end
            step();
        end
        clr_in(); set_idle(); step();
    endtask

    // Reset asserted while a word store waits for grant.
    task automatic reset_in_wreq();
        clr_in();
        bus.req_valid_i = 1'b1; bus.req_size_i = 2'b10;
        bus.req_addr_i = 32'h0000_6008; bus.req_wdata_i = 32'h1357_9BDF;
        set_idle(); step();
        clr_in();
        set_busy(); exp.mreq = 1'b1; exp.we = 1'b1; exp.addr = 32'h0000_6008;
        exp.wdata = 32'h1357_9BDF; exp.strb = 4'hF;
        step();
        rst = 1'b0;
        exp = '0;
        step();
        exp = '0;
        step();
        rst = 1'b1;
        set_idle(); step();
        set_idle(); step();
    endtask

    initial begin
        logic [31:0] sb_lit, sh_lit;
        rst = 1'b0;
        clr_in();
        exp = '0;
        chk_en = 1'b1;
        step(); step();
        rst = 1'b1;
        set_idle(); step();

        // lb / lhu / misaligned lw and friends
        access(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 5'd5, 0, 0, 32'h8011_2233,
               -1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF80);
        access(1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'd0, 5'd7, 1, 2, 32'hBEEF_1234,
               -1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF);
        access(1'b1, 2'b10, 1'b0, 32'h0000_2001, 32'd0, 5'd1, 0, 0, 32'd0,
               -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        access(1'b1, 2'b11, 1'b0, 32'h0000_2000, 32'd0, 5'd2, 0, 0, 32'd0,
               -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        access(1'b0, 2'b01, 1'b0, 32'h0000_2003, 32'h55, 5'd0, 0, 0, 32'd0,
               -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        access(1'b1, 2'b01, 1'b0, 32'h0000_2000, 32'd0, 5'd9, 0, 0, 32'h1234_8001,
               -1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_8001);
        access(1'b1, 2'b00, 1'b1, 32'h0000_1001, 32'd0, 5'd11, 0, 1, 32'h0000_9A00,
               -1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_009A);
        // rvalid coinciding with grant must be ignored
        access(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'd0, 5'd31, 0, 1, 32'hCAFE_F00D,
               -1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
        // grant held off 5 cycles, then the same with a flush in the third cycle
        access(1'b1, 2'b10, 1'b0, 32'h0000_7004, 32'd0, 5'd3, 5, 0, 32'h0BAD_CAFE,
               -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        access(1'b1, 2'b10, 1'b0, 32'h0000_7008, 32'd0, 5'd4, 5, 0, 32'h0BAD_CAFE,
               2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        // flush during RWAIT suppresses the writeback
        access(1'b1, 2'b10, 1'b0, 32'h0000_700C, 32'd0, 5'd6, 0, 2, 32'h7777_7777,
               -1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        // stores
        access(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'hDEAD_BEEF, 5'd0, 2, 0, 32'd0,
               -1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
`ifdef LSU_BYTE_STROBE_EN
        sb_lit = 32'hAAAA_AAAA;
        sh_lit = 32'h5678_5678;
`else
        sb_lit = 32'h1122_AA44;
        sh_lit = 32'h5678_3344;
`endif
        access(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00AA, 5'd0, 0, 0, 32'h1122_3344,
               -1, 1'b0, 1'b0, 1'b0, 1'b1, sb_lit);
        access(1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_5678, 5'd0, 1, 1, 32'h1122_3344,
               -1, 1'b0, 1'b0, 1'b0, 1'b1, sh_lit);
        access(1'b0, 2'b00, 1'b0, 32'h0000_3003, 32'h0000_0077, 5'd0, 0, 1, 32'h1122_3344,
               -1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        reset_in_wreq();
        // load after reset recovery
        access(1'b1, 2'b00, 1'b0, 32'h0000_1002, 32'd0, 5'd12, 0, 0, 32'h0042_0000,
               -1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0042);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and the reset rst; reset SHALL be asynchronous and active-low.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  clock
  rst  in  1  async active-low reset
  req_valid_i  in  1  access request from execute stage
  req_ready_o  out  1  request accepted this cycle
  req_load_i  in  1  1=load, 0=store
  req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
  req_unsigned_i  in  1  zero-extend load
  req_addr_i  in  32  byte address (op1+op2 already summed)
  req_wdata_i  in  32  store data (rs2)
  req_rd_i  in  5  load destination register
  flush_i  in  1  interrupt or pipeline flush
  mem_req_o  out  1  bus request, held until grant
  mem_we_o  out  1  bus write
  mem_addr_o  out  32  word-aligned bus address, bits [1:0]=0
  mem_wdata_o  out  32  bus write data
  mem_wstrb_o  out  4  byte strobes
  mem_gnt_i  in  1  bus grant
  mem_rvalid_i  in  1  read data valid
  mem_rdata_i  in  32  read data
  reg_we_o, reg_waddr_o[4:0], reg_wdata_o[31:0]  out  registered load writeback
  misalign_o  out  1  one-cycle misaligned-access pulse
  busy_o  out  1  state != IDLE

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, RREQ, RWAIT, WREQ.
REQ-004 req_ready_o SHALL be 1 only in IDLE with flush_i=0; a request is accepted on req_valid_i & req_ready_o, and all req_* fields are captured on that edge.
REQ-005 Misalignment (half with addr[0]=1, word with addr[1:0]!=0, or size=11) SHALL produce misalign_o=1 in the next cycle only, with no bus activity and the FSM remaining in IDLE.
REQ-006 Load: IDLE->RREQ; in RREQ, mem_req_o=1, mem_we_o=0; on mem_gnt_i go to RWAIT; in RWAIT, on mem_rvalid_i go to IDLE.
REQ-007 Load data SHALL be lane-selected by addr[1:0] and sign- or zero-extended per req_unsigned_i; reg_we_o SHALL pulse for exactly one cycle, the cycle after rvalid, with reg_waddr_o=rd.
REQ-008 Store: mem_we_o=1 and mem_req_o=1 in WREQ until mem_gnt_i, then go to IDLE; sw SHALL write req_wdata_i unchanged.
REQ-009 mem_rvalid_i SHALL be ignored outside RWAIT, including when it coincides with the grant in RREQ.
REQ-010 flush_i in RREQ before grant SHALL drop mem_req_o next cycle and return to IDLE.
REQ-011 flush_i in RWAIT SHALL wait for rvalid, suppress the writeback and any RMW write, then return to IDLE.
REQ-012 flush_i in WREQ SHALL be ignored; the store SHALL complete.
REQ-013 Outside the states that drive them, mem_addr_o and mem_wdata_o SHALL be 0, and reg_wdata_o SHALL be 0 when reg_we_o=0.

Reset
REQ-014 While rst=0, the FSM SHALL be IDLE, every output SHALL be 0 except req_ready_o (0 during reset), and the capture and merge registers SHALL be cleared.
REQ-015 Reset asserted mid-transaction SHALL abandon it; no writeback or grant-wait SHALL survive reset.

Configuration
REQ-016 With LSU_BYTE_STROBE_EN defined, every store SHALL go IDLE->WREQ directly. sb SHALL replicate the byte to all lanes with mem_wstrb_o=1<<addr[1:0]. sh SHALL replicate the halfword, with strobe 0011 or 1100. sw SHALL use strobe 1111. Total store latency SHALL be 1 cycle plus grant wait.
REQ-017 Without LSU_BYTE_STROBE_EN, mem_wstrb_o SHALL be tied to 4'hF. sb and sh SHALL do read-modify-write: RREQ->RWAIT, merge rs2 into the addressed lanes of mem_rdata_i on rvalid, then WREQ. sw SHALL go directly to WREQ.

Verification
REQ-018 Load lb, addr=0x1003, gnt same cycle, rvalid next cycle with rdata=0x80112233 -> reg_wdata_o=0xFFFFFF80 and reg_we_o high for exactly 1 cycle, 3 cycles after accept.
REQ-019 lhu addr=0x2002, rdata=0xBEEF1234 -> reg_wdata_o=0x0000BEEF; lw addr=0x2001 -> misalign_o pulse, mem_req_o stays 0.
REQ-020 sb addr=0x3001, wdata=0xAA, without macro, rdata=0x11223344 -> mem_wdata_o=0x1122AA44 with we=1; with macro -> mem_wdata_o=0xAAAAAAAA and mem_wstrb_o=0010 with no read.
REQ-021 Load with gnt held low 5 cycles -> mem_req_o and mem_addr_o stable all 5 cycles; flush_i in cycle 3 -> mem_req_o=0 next cycle, FSM IDLE, no writeback.
REQ-022 flush_i during RWAIT, and separately reset asserted in WREQ -> the first gives no reg_we_o after rvalid; the second drives all outputs to 0 immediately and busy_o=0.
